// File: rtl/fetch_prefetch_pkg.sv
// Shared definitions for the prefetching fetch stage.
//   EX_INSTR_ADDR_MISALIGN : exception code reported for a misaligned redirect
//   fetch_state_e          : RUN (fetching), EXC (exception entry at head),
//                            HALT (parked until the next redirect)
//   *_DEF                  : default bus widths shared by the interface and top
package fetch_prefetch_pkg;

  localparam int ADDR_W_DEF  = 32;
  localparam int INSTR_W_DEF = 32;
  localparam int EX_W_DEF    = 4;

  // Instruction address misaligned (RISC-V cause 0).
  localparam logic [3:0] EX_INSTR_ADDR_MISALIGN = 4'd0;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_EXC  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_prefetch_if.sv
// Bus bundle between the fetch stage, instruction memory and decode.
//   Memory side : mem_req_valid/mem_req_addr/mem_req_ready (request handshake),
//                 mem_resp_valid/mem_resp_data (in-order read data, always taken)
//   Decode side : instr/PC/pipeline_valid/exception/exception_valid (FIFO head),
//                 stall (head held), flush/flush_addr (redirect)
// modport master : the fetch stage
// modport slave  : the environment (memory + decode)
interface fetch_prefetch_if import fetch_prefetch_pkg::*; #(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF,
  parameter int EX_W    = EX_W_DEF
);

  logic               mem_req_valid;
  logic [ADDR_W-1:0]  mem_req_addr;
  logic               mem_req_ready;
  logic               mem_resp_valid;
  logic [INSTR_W-1:0] mem_resp_data;
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  PC;
  logic               pipeline_valid;
  logic [EX_W-1:0]    exception;
  logic               exception_valid;
  logic               stall;
  logic               flush;
  logic [ADDR_W-1:0]  flush_addr;

  modport master (
    output mem_req_valid, mem_req_addr, instr, PC, pipeline_valid,
           exception, exception_valid,
    input  mem_req_ready, mem_resp_valid, mem_resp_data, stall, flush,
           flush_addr
  );

  modport slave (
    input  mem_req_valid, mem_req_addr, instr, PC, pipeline_valid,
           exception, exception_valid,
    output mem_req_ready, mem_resp_valid, mem_resp_data, stall, flush,
           flush_addr
  );

endinterface

// File: rtl/fetch_prefetch_fifo.sv
// fetch_fifo: synchronous FIFO holding {PC, instr} entries for the fetch stage.
//   clk, reset_n : clock, asynchronous active-low reset (pointers/count only)
//   clear        : drop all entries (wins over push/pop)
//   push, wdata  : write an entry
//   pop          : advance the head (ignored when empty)
//   rdata        : head entry, read straight from storage
//   count, full, empty : occupancy
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign pop_ok  = pop & ~empty;
  // A push into a full FIFO is fine when the head leaves in the same cycle.
  assign push_ok = push & (~full | pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push_ok && !clear) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/fetch_prefetch.sv
// fetch_prefetch: prefetching instruction fetch stage.
// Keeps up to DEPTH requests in flight or buffered, queues returned
// instructions with their PCs and presents one per cycle to decode.
//   clk     : clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : fetch_prefetch_if.master (memory request/response, decode head,
//             stall, flush/flush_addr)
// A flush turns every in-flight request into a stale response that is
// counted off in drop_cnt_q; a misaligned target parks an exception entry at
// the head, then the stage halts until the next flush.
module fetch_prefetch import fetch_prefetch_pkg::*; #(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter int                INSTR_W  = INSTR_W_DEF,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                EX_W     = EX_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  fetch_prefetch_if.master  bus
);

  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int FIFO_W = ADDR_W + INSTR_W;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]  outstanding_q, outstanding_d;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

  logic              issue_en, exc_active;
  logic              credit_ok, fire, resp_drop;
  logic              fifo_push, fifo_pop;
  logic [FIFO_W-1:0] fifo_rdata;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full, fifo_empty;

  // Buffered plus outstanding never exceeds DEPTH, so responses always fit.
  assign credit_ok = ({1'b0, fifo_count} + {1'b0, outstanding_q}) < DEPTH_C;

  // reset_n gates the request combinationally so it drops the instant reset hits.
  assign bus.mem_req_valid = reset_n & issue_en & ~bus.flush & credit_ok & ~fifo_full;
  assign bus.mem_req_addr  = fetch_pc_q;
  assign fire              = bus.mem_req_valid & bus.mem_req_ready;

  assign resp_drop = bus.mem_resp_valid & (drop_cnt_q != '0);
  assign fifo_push = bus.mem_resp_valid & ~bus.flush & (drop_cnt_q == '0);
  assign fifo_pop  = ~fifo_empty & ~bus.stall & ~bus.flush;

  fetch_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (bus.flush),
    .push    (fifo_push),
    .wdata   ({pc_q, bus.mem_resp_data}),
    .pop     (fifo_pop),
    .rdata   (fifo_rdata),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_RUN;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.flush) begin
      state_d = (bus.flush_addr[1:0] == 2'b00) ? ST_RUN : ST_EXC;
    end else begin
      case (state_q)
        ST_RUN:  state_d = ST_RUN;
        ST_EXC:  state_d = bus.stall ? ST_EXC : ST_HALT;
        ST_HALT: state_d = ST_HALT;
        default: state_d = ST_HALT;
      endcase
    end
  end

  always_comb begin
    issue_en   = 1'b0;
    exc_active = 1'b0;
    case (state_q)
      ST_RUN:  issue_en   = 1'b1;
      ST_EXC:  exc_active = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    pc_d       = pc_q;
    drop_cnt_d = drop_cnt_q;
    if (bus.flush) begin
      fetch_pc_d = bus.flush_addr;
      pc_d       = bus.flush_addr;
      // The response landing in the flush cycle is already discarded.
      drop_cnt_d = outstanding_q - CNT_W'(bus.mem_resp_valid);
    end else begin
      if (fire)      fetch_pc_d = fetch_pc_q + ADDR_W'(4);
      if (fifo_push) pc_d       = pc_q + ADDR_W'(4);
      if (resp_drop) drop_cnt_d = drop_cnt_q - CNT_W'(1);
    end
    case ({fire, bus.mem_resp_valid})
      2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
      2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
      default: outstanding_d = outstanding_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc_q    <= RESET_PC;
      pc_q          <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  // In EXC the FIFO is empty and pc_q still holds the redirect target.
  assign bus.pipeline_valid  = exc_active | ~fifo_empty;
  assign bus.exception_valid = exc_active;
  assign bus.exception       = exc_active ? EX_W'(EX_INSTR_ADDR_MISALIGN) : '0;
  assign bus.PC              = exc_active ? pc_q :
                               (fifo_empty ? '0 : fifo_rdata[FIFO_W-1 -: ADDR_W]);
  assign bus.instr           = (exc_active | fifo_empty) ? '0 : fifo_rdata[INSTR_W-1:0];

endmodule
